// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg : shared pointer types and Gray/binary helpers for the    |
// | async FIFO pointer blocks.                     Rev 1.0             |
// +--------------------------------------------------------------------+
package fifo_pkg;

   localparam int DEF_ADDR_SIZE = 3;
   localparam int DEF_PTR_W     = DEF_ADDR_SIZE + 1;
   localparam int MAX_PTR_W     = 32;

   typedef logic [DEF_PTR_W-1:0] ptr_t;
   typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

   // One extra pointer bit distinguishes full from empty.
   function automatic int ptr_width(input int addr_size);
      return addr_size + 1;
   endfunction

   function automatic wide_ptr_t bin2gray(input wide_ptr_t b);
      return (b >> 1) ^ b;
   endfunction

   function automatic wide_ptr_t gray2bin(input wide_ptr_t g);
      wide_ptr_t b;
      b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
      for (int i = MAX_PTR_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wptr_full_if : write-side FIFO pointer/flag bundle.           |
// |                                               Rev 1.0             |
// +--------------------------------------------------------------------+
interface fifo_wptr_full_if
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE = 3
);
   localparam int PTR_W = ptr_width(ADDR_SIZE);

   logic                 winc;
   logic [PTR_W-1:0]     wq2_rptr;
   logic                 wovf_clr;
   logic                 wen;
   logic [ADDR_SIZE-1:0] waddr;
   logic [PTR_W-1:0]     wptr;
   logic                 wfull;
   logic                 walmost_full;
   logic [PTR_W-1:0]     wlevel;
   logic                 woverflow;

   modport master (
      output winc, wq2_rptr, wovf_clr,
      input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
   );

   modport slave (
      input  winc, wq2_rptr, wovf_clr,
      output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
   );

endinterface
`default_nettype wire

// File: rtl/fifo_gray_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_gray_cnt : registered binary + Gray pointer with increment    |
// | enable, shared by the FIFO read and write sides.  Rev 1.0          |
// +--------------------------------------------------------------------+
module fifo_gray_cnt
   import fifo_pkg::*;
#(
   parameter  int ADDR_SIZE = 3,
   localparam int PTR_W     = ptr_width(ADDR_SIZE)
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 inc,
   output logic      [ADDR_SIZE-1:0] addr,
   output logic      [PTR_W-1:0]     bin_next,
   output logic      [PTR_W-1:0]     gray_next,
   output logic      [PTR_W-1:0]     gray
);

   logic [PTR_W-1:0] bin;

   assign bin_next  = bin + {{(PTR_W-1){1'b0}}, inc};
   assign gray_next = PTR_W'(bin2gray(MAX_PTR_W'(bin_next)));
   assign addr      = bin[ADDR_SIZE-1:0];

   // Gray is registered straight from the next-state value so it crosses clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin  <= '0;
         gray <= '0;
      end else begin
         bin  <= bin_next;
         gray <= gray_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wptr_full : async FIFO write pointer, full/almost-full/level  |
// | flags. Optional sticky overflow flag: FIFO_WOVERFLOW_EN.  Rev 1.0  |
// +--------------------------------------------------------------------+
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE = 3,
   parameter int AFULL_TH  = 6
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   fifo_wptr_full_if.slave    bus
);

   localparam int               PTR_W     = ptr_width(ADDR_SIZE);
   localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_TH);

   logic             inc;
   logic [PTR_W-1:0] wbin_next;
   logic [PTR_W-1:0] wgray_next;
   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] full_gray;
   logic [PTR_W-1:0] level_next;
   logic             full_q;
   logic             afull_q;
   logic [PTR_W-1:0] level_q;

   assign inc     = bus.winc & ~full_q;
   assign bus.wen = inc;

   fifo_gray_cnt #(
      .ADDR_SIZE (ADDR_SIZE)
   ) u_wcnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc),
      .addr      (bus.waddr),
      .bin_next  (wbin_next),
      .gray_next (wgray_next),
      .gray      (bus.wptr)
   );

   // Full when the write pointer is one lap ahead: top two Gray bits inverted.
   assign full_gray  = {~bus.wq2_rptr[PTR_W-1:PTR_W-2], bus.wq2_rptr[PTR_W-3:0]};
   assign rbin       = PTR_W'(gray2bin(MAX_PTR_W'(bus.wq2_rptr)));
   assign level_next = wbin_next - rbin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         level_q <= '0;
      end else begin
         full_q  <= (wgray_next == full_gray);
         afull_q <= (level_next >= AFULL_LVL);
         level_q <= level_next;
      end
   end

   assign bus.wfull        = full_q;
   assign bus.walmost_full = afull_q;
   assign bus.wlevel       = level_q;

`ifdef FIFO_WOVERFLOW_EN
   logic ovf_q;

   // Set has priority so an overflow in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (bus.winc & full_q) begin
         ovf_q <= 1'b1;
      end else if (bus.wovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign bus.woverflow = ovf_q;
`else
   logic unused_ovf_clr;

   assign unused_ovf_clr = bus.wovf_clr;
   assign bus.woverflow  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// Bench for fifo_wptr_full: integer occupancy model compared every cycle,
// plus directed literal checks of reset, fill, drain, wrap and overflow.
module tb_fifo_wptr_full;
   import fifo_pkg::*;

   localparam int ADDR_SIZE = 3;
   localparam int AFULL_TH  = 6;
   localparam int PTR_W     = 4;
   localparam int DEPTH     = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fifo_wptr_full_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

   fifo_wptr_full #(
      .ADDR_SIZE (ADDR_SIZE),
      .AFULL_TH  (AFULL_TH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_pass = 0;
   int   m_wr, m_full, m_afull, m_level, m_ovf;
   int   rd_seen = 0;
   int   rd_actual = 0;
   ptr_t prev_wptr = '0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int gray(input int n);
      int b;
      b = n % (1 << PTR_W);
      return b ^ (b >> 1);
   endfunction

   // Reference: count accepted writes and reads seen; occupancy is their difference.
   always @(posedge clk or negedge rst_n) begin : model
      int occ;
      bit acc;
      if (!rst_n) begin
         m_wr = 0; m_full = 0; m_afull = 0; m_level = 0; m_ovf = 0;
      end else begin
         acc = bus.winc && (m_full == 0);
`ifdef FIFO_WOVERFLOW_EN
         if (bus.winc && m_full != 0) m_ovf = 1;
         else if (bus.wovf_clr)       m_ovf = 0;
`endif
         m_wr    = m_wr + int'(acc);
         occ     = m_wr - rd_seen;
         m_full  = int'(occ == DEPTH);
         m_afull = int'(occ >= AFULL_TH);
         m_level = occ;
      end
   end

   always @(negedge clk) begin : compare
      if (rst_n) begin
         check("wen",          int'(bus.wen),          int'(bus.winc && m_full == 0));
         check("waddr",        int'(bus.waddr),        m_wr % DEPTH);
         check("wptr",         int'(bus.wptr),         gray(m_wr));
         check("wfull",        int'(bus.wfull),        m_full);
         check("walmost_full", int'(bus.walmost_full), m_afull);
         check("wlevel",       int'(bus.wlevel),       m_level);
         check("woverflow",    int'(bus.woverflow),    m_ovf);
         check("wptr_one_bit_step", int'($countones(bus.wptr ^ prev_wptr) <= 1), 1);
         check("wlevel_pessimistic", int'(int'(bus.wlevel) >= m_wr - rd_actual), 1);
         prev_wptr = bus.wptr;
      end else begin
         prev_wptr = '0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_rd(input int seen);
      rd_seen      = seen;
      bus.wq2_rptr = PTR_W'(gray(seen));
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.winc     = 1'b0;
      bus.wovf_clr = 1'b0;
      rd_actual    = 0;
      set_rd(0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin : stim
      int seq [0:8];
      int p1, p2, w1, w2;
      seq = '{0, 1, 3, 2, 6, 7, 5, 4, 12};

      // Reset in the middle of traffic
      do_reset();
      bus.winc = 1'b1;
      repeat (3) tick();
      bus.winc = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_wptr",  int'(bus.wptr),         0);
      check("rst_waddr", int'(bus.waddr),        0);
      check("rst_wfull", int'(bus.wfull),        0);
      check("rst_afull", int'(bus.walmost_full), 0);
      check("rst_level", int'(bus.wlevel),       0);
      check("rst_ovf",   int'(bus.woverflow),    0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      bus.winc = 1'b1;
      #1;
      check("post_rst_waddr", int'(bus.waddr), 0);
      check("post_rst_wen",   int'(bus.wen),   1);
      tick();
      check("post_rst_waddr_adv", int'(bus.waddr), 1);

      // Fill past full
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         bus.winc = 1'b1;
         #1;
         if (k >= 9) check("fill_wen_refused", int'(bus.wen), 0);
         tick();
         check("fill_wptr",  int'(bus.wptr),         seq[(k > 8) ? 8 : k]);
         check("fill_afull", int'(bus.walmost_full), int'(k >= 6));
         check("fill_full",  int'(bus.wfull),        int'(k >= 8));
      end
      check("fill_waddr_hold", int'(bus.waddr), 0);

      // Drain one entry from full
      bus.winc  = 1'b0;
      rd_actual = 1;
      set_rd(1);
      tick();
      check("drain_full",  int'(bus.wfull),  0);
      check("drain_level", int'(bus.wlevel), 7);
      bus.winc = 1'b1;
      tick();
      check("refill_full",  int'(bus.wfull),  1);
      check("refill_level", int'(bus.wlevel), 8);
      bus.winc = 1'b0;

      // Pointer wrap with reader trailing by two clocks
      do_reset();
      for (int i = 0; i < 20; i++) begin
         bus.winc = 1'b1;
         set_rd((i >= 2) ? i - 2 : 0);
         rd_actual = rd_seen;
         tick();
         if (i == 14) check("wrap_wptr_15", int'(bus.wptr), 8);
         if (i == 15) check("wrap_wptr_16", int'(bus.wptr), 0);
         check("wrap_no_full", int'(bus.wfull), 0);
      end

      // Writes while full
      do_reset();
      bus.winc = 1'b1;
      repeat (9) tick();
`ifdef FIFO_WOVERFLOW_EN
      check("ovf_set", int'(bus.woverflow), 1);
      tick();
      check("ovf_hold", int'(bus.woverflow), 1);
      bus.wovf_clr = 1'b1;
      tick();
      check("ovf_set_beats_clr", int'(bus.woverflow), 1);
      bus.winc = 1'b0;
      tick();
      check("ovf_clr", int'(bus.woverflow), 0);
`else
      check("ovf_absent", int'(bus.woverflow), 0);
      bus.wovf_clr = 1'b1;
      tick();
      check("ovf_absent_clr", int'(bus.woverflow), 0);
`endif
      bus.wovf_clr = 1'b0;
      bus.winc     = 1'b0;

      // Random writer against a randomly paced, two-clock-delayed reader
      do_reset();
      p1 = 0; p2 = 0; w1 = 0; w2 = 0;
      for (int c = 0; c < 10000; c++) begin
         bus.winc     = ($urandom_range(0, 3) != 0);
         bus.wovf_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 2) != 0 && rd_actual < w2) rd_actual++;
         set_rd(p2);
         p2 = p1; p1 = rd_actual;
         w2 = w1; w1 = m_wr;
         tick();
      end
      bus.winc     = 1'b0;
      bus.wovf_clr = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      bus.winc     = 1'b0;
      bus.wovf_clr = 1'b0;
      bus.wq2_rptr = '0;
   end

endmodule
`default_nettype wire
